// File: rtl/image_loader.sv
// Raster-order BRAM writer: accepts pixels over valid/ready, generates linear
// addresses incrementally, checks line framing and reports frame completion.
module image_loader #(
   parameter int MAX_ROW = 360,
   parameter int MAX_COL = 540,
   parameter int ADDR_W  = 18
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_start_i,
   input  logic              hold_i,
   input  logic [7:0]        pixel_i,
   input  logic              pixel_valid_i,
   input  logic              pixel_eol_i,
   output logic              pixel_ready_o,
   output logic              ena_o,
   output logic              wea_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic [7:0]        d2mem_o,
   output logic [9:0]        cnt_row_o,
   output logic              busy_o,
   output logic              load_done_o,
   output logic              line_err_o
);

   localparam int COL_W = (MAX_COL > 1) ? $clog2(MAX_COL) : 1;

   localparam logic [COL_W-1:0]  LAST_COL = COL_W'(MAX_COL - 1);
   localparam logic [9:0]        LAST_ROW = 10'(MAX_ROW - 1);
   localparam logic [ADDR_W-1:0] COL_STEP = ADDR_W'(MAX_COL);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_DONE
   } state_t;

   state_t r_state;
   state_t w_next_state;

   logic [COL_W-1:0]  r_col;
   logic [9:0]        r_row;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] r_row_base;
   logic              r_line_err;

   logic              r_ena;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [7:0]        r_wr_data;

   logic              w_in_load;
   logic              w_accept;
   logic              w_last_col;
   logic              w_row_end;
   logic              w_frame_end;
   logic [ADDR_W-1:0] w_next_row_base;

   // A restart in the same cycle as a beat wins: the beat is dropped.
   assign w_in_load       = (r_state == S_LOAD);
   assign w_accept        = w_in_load && pixel_valid_i && !hold_i && !load_start_i;
   assign w_last_col      = (r_col == LAST_COL);
   assign w_row_end       = pixel_eol_i || w_last_col;
   assign w_frame_end     = w_accept && w_row_end && (r_row == LAST_ROW);
   assign w_next_row_base = r_row_base + COL_STEP;

   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         S_IDLE: if (load_start_i) w_next_state = S_LOAD;
         S_LOAD: begin
            if (load_start_i)     w_next_state = S_LOAD;
            else if (w_frame_end) w_next_state = S_DONE;
         end
         S_DONE: w_next_state = load_start_i ? S_LOAD : S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next_state;
   end

   // Row/column/address bookkeeping; row_base tracks col 0 of the current row
   // so an early eol can jump straight to the next row without a multiplier.
   always_ff @(posedge clk) begin
      if (rst || load_start_i) begin
         r_col      <= '0;
         r_row      <= '0;
         r_addr     <= '0;
         r_row_base <= '0;
         r_line_err <= 1'b0;
      end else if (w_accept) begin
         if (w_row_end) begin
            r_col      <= '0;
            r_row      <= r_row + 10'd1;
            r_addr     <= w_next_row_base;
            r_row_base <= w_next_row_base;
            if (pixel_eol_i != w_last_col) r_line_err <= 1'b1;
         end else begin
            r_col  <= r_col + COL_W'(1);
            r_addr <= r_addr + ADDR_W'(1);
         end
      end
   end

   // BRAM write port, registered: a write lands one cycle after its accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ena     <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
      end else begin
         r_ena <= w_accept;
         if (w_accept) begin
            r_wr_addr <= r_addr;
            r_wr_data <= pixel_i;
         end
      end
   end

   assign pixel_ready_o = w_in_load && !hold_i;
   assign busy_o        = w_in_load;
   assign load_done_o   = (r_state == S_DONE) && !load_start_i;
   assign ena_o         = r_ena;
   assign wea_o         = r_ena;
   assign addr_o        = r_wr_addr;
   assign d2mem_o       = r_wr_data;
   assign cnt_row_o     = r_row;
   assign line_err_o    = r_line_err;

endmodule

// File: tb/tb_image_loader.sv
// Scoreboard bench for image_loader on a reduced 4x8 frame: the driver queues
// expected writes, a negedge monitor pops and compares each BRAM write.
module tb_image_loader;

   localparam int MAX_ROW = 4;
   localparam int MAX_COL = 8;
   localparam int ADDR_W  = 5;

   logic              clk;
   logic              rst;
   logic              load_start_i;
   logic              hold_i;
   logic [7:0]        pixel_i;
   logic              pixel_valid_i;
   logic              pixel_eol_i;
   logic              pixel_ready_o;
   logic              ena_o;
   logic              wea_o;
   logic [ADDR_W-1:0] addr_o;
   logic [7:0]        d2mem_o;
   logic [9:0]        cnt_row_o;
   logic              busy_o;
   logic              load_done_o;
   logic              line_err_o;

   image_loader #(
      .MAX_ROW (MAX_ROW),
      .MAX_COL (MAX_COL),
      .ADDR_W  (ADDR_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .load_start_i  (load_start_i),
      .hold_i        (hold_i),
      .pixel_i       (pixel_i),
      .pixel_valid_i (pixel_valid_i),
      .pixel_eol_i   (pixel_eol_i),
      .pixel_ready_o (pixel_ready_o),
      .ena_o         (ena_o),
      .wea_o         (wea_o),
      .addr_o        (addr_o),
      .d2mem_o       (d2mem_o),
      .cnt_row_o     (cnt_row_o),
      .busy_o        (busy_o),
      .load_done_o   (load_done_o),
      .line_err_o    (line_err_o)
   );

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [7:0]        data;
      int                cyc;
   } wr_t;

   wr_t exp_q[$];
   wr_t mon_e;
   int  checks   = 0;
   int  errors   = 0;
   int  cyc      = 0;
   int  done_cnt = 0;
   bit  mon_on   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every BRAM write must match the head of the queue, on time.
   always @(negedge clk) begin
      if (mon_on) begin
         if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL write_missing: addr %0d expected at cycle %0d, now %0d",
                     exp_q[0].addr, exp_q[0].cyc, cyc);
            void'(exp_q.pop_front());
         end
         if (ena_o || wea_o) begin
            check("wea_eq_ena", 32'(wea_o), 32'(ena_o));
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: addr %0d data %0d at cycle %0d", addr_o, d2mem_o, cyc);
            end else begin
               mon_e = exp_q.pop_front();
               check("wr_addr", 32'(addr_o), 32'(mon_e.addr));
               check("wr_data", 32'(d2mem_o), 32'(mon_e.data));
               check("wr_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
         end
         if (load_done_o) begin
            done_cnt++;
            check("done_with_final_write", 32'(ena_o), 32'd1);
         end
      end
   end

   // One clock of stimulus; exp_acc queues the write the beat should cause.
   task automatic beat(input logic [7:0] d, input logic eol, input logic valid,
                       input logic hold, input logic start,
                       input logic exp_rdy, input logic exp_acc, input int exp_addr);
      wr_t e;
      pixel_i       = d;
      pixel_eol_i   = eol;
      pixel_valid_i = valid;
      hold_i        = hold;
      load_start_i  = start;
      if (exp_acc) begin
         e.addr = ADDR_W'(exp_addr);
         e.data = d;
         e.cyc  = cyc + 1;
         exp_q.push_back(e);
      end
      @(negedge clk);
      check("pixel_ready", 32'(pixel_ready_o), 32'(exp_rdy));
      @(posedge clk);
      #1;
      load_start_i  = 1'b0;
      pixel_valid_i = 1'b0;
      pixel_eol_i   = 1'b0;
      hold_i        = 1'b0;
   endtask

   function automatic logic [7:0] pix(input int a);
      return 8'(a) ^ 8'hA5;
   endfunction

   task automatic send_row(input int r, input int ncols, input logic eol_last);
      for (int c = 0; c < ncols; c++)
         beat(pix(r*MAX_COL + c), (c == ncols-1) ? eol_last : 1'b0, 1'b1, 1'b0, 1'b0,
              1'b1, 1'b1, r*MAX_COL + c);
   endtask

   task automatic send_frame();
      for (int r = 0; r < MAX_ROW; r++) send_row(r, MAX_COL, 1'b1);
   endtask

   initial begin
      int  k;
      int  a;
      bit  acc;
      bit  v;
      bit  h;

      rst = 1'b1; load_start_i = 1'b0; hold_i = 1'b0;
      pixel_i = '0; pixel_valid_i = 1'b0; pixel_eol_i = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("rst_ena", 32'(ena_o), 32'd0);
      check("rst_wea", 32'(wea_o), 32'd0);
      check("rst_addr", 32'(addr_o), 32'd0);
      check("rst_data", 32'(d2mem_o), 32'd0);
      check("rst_cnt_row", 32'(cnt_row_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_done", 32'(load_done_o), 32'd0);
      check("rst_err", 32'(line_err_o), 32'd0);
      check("rst_ready", 32'(pixel_ready_o), 32'd0);
      rst    = 1'b0;
      mon_on = 1'b1;

      // Clean frame, valid held high; a beat in DONE must be ignored.
      beat(8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
      check("t1_busy", 32'(busy_o), 32'd1);
      check("t1_cnt_row_start", 32'(cnt_row_o), 32'd0);
      send_frame();
      beat(8'h55, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      beat(8'h66, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      check("t1_done_cnt", 32'(done_cnt), 32'd1);
      check("t1_cnt_row", 32'(cnt_row_o), 32'(MAX_ROW));
      check("t1_err", 32'(line_err_o), 32'd0);
      check("t1_busy_idle", 32'(busy_o), 32'd0);

      // Gapped valid and periodic hold bursts.
      beat(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
      k = 0;
      for (int p = 0; p < MAX_ROW*MAX_COL; p++) begin
         acc = 1'b0;
         while (!acc) begin
            h   = (k % 12) >= 9;
            v   = (k % 5) != 2;
            acc = v && !h;
            beat(pix(p), (p % MAX_COL) == MAX_COL-1, v, h, 1'b0, !h, acc, p);
            k++;
         end
      end
      beat(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      check("t2_done_cnt", 32'(done_cnt), 32'd2);
      check("t2_cnt_row", 32'(cnt_row_o), 32'(MAX_ROW));

      // Early eol in row 2 after three pixels.
      beat(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
      send_row(0, MAX_COL, 1'b1);
      send_row(1, MAX_COL, 1'b1);
      check("t3_err_before", 32'(line_err_o), 32'd0);
      send_row(2, 3, 1'b1);
      check("t3_err_after", 32'(line_err_o), 32'd1);
      check("t3_cnt_row", 32'(cnt_row_o), 32'd3);
      send_row(3, MAX_COL, 1'b1);
      beat(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      check("t3_done_cnt", 32'(done_cnt), 32'd3);
      check("t3_err_sticky", 32'(line_err_o), 32'd1);

      // Missing eol at the end of row 0; start clears the sticky flag.
      beat(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
      check("t4_err_cleared", 32'(line_err_o), 32'd0);
      send_row(0, MAX_COL, 1'b0);
      check("t4_err_set", 32'(line_err_o), 32'd1);
      check("t4_cnt_row", 32'(cnt_row_o), 32'd1);
      send_row(1, 3, 1'b0);

      // Abort mid-frame with valid high: that beat is dropped.
      a = MAX_COL + 3;
      beat(pix(a), 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0);
      check("t5_cnt_row", 32'(cnt_row_o), 32'd0);
      check("t5_err", 32'(line_err_o), 32'd0);
      check("t5_busy", 32'(busy_o), 32'd1);
      check("t5_no_done", 32'(done_cnt), 32'd3);
      send_frame();
      beat(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      check("t5_done_cnt", 32'(done_cnt), 32'd4);

      // Restart landing on the DONE cycle suppresses the done pulse.
      beat(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
      send_frame();
      beat(8'h77, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
      check("t6_done_suppressed", 32'(done_cnt), 32'd4);
      check("t6_busy", 32'(busy_o), 32'd1);
      check("t6_cnt_row", 32'(cnt_row_o), 32'd0);

      // Synchronous reset mid-row with valid high.
      send_row(0, MAX_COL, 1'b1);
      send_row(1, MAX_COL, 1'b1);
      send_row(2, 3, 1'b0);
      rst = 1'b1; pixel_valid_i = 1'b1; pixel_i = 8'h99;
      @(posedge clk);
      #1;
      check("t7_ena", 32'(ena_o), 32'd0);
      check("t7_wea", 32'(wea_o), 32'd0);
      check("t7_ready", 32'(pixel_ready_o), 32'd0);
      check("t7_cnt_row", 32'(cnt_row_o), 32'd0);
      check("t7_busy", 32'(busy_o), 32'd0);
      rst = 1'b0; pixel_valid_i = 1'b0;
      beat(8'h42, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      beat(8'h43, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);
      check("final_done_cnt", 32'(done_cnt), 32'd4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
